// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the core ports, the arbiter and the unified memory.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_rdy;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rdy;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  logic              err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    output if_rdata, if_rdy, d_rdata, d_rdy, mem_en, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    input  if_rdata, if_rdy, d_rdata, d_rdy, mem_en, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction at a time, with starvation protection and a response watchdog.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input logic                  CLK,
  input logic                  resetl,
  unified_mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] WD_LAST    = TW'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              win_data_q, win_data_d;
  logic              is_store_q, is_store_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     wd_q, wd_d;
  logic              err_q, err_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              if_rdy_q, if_rdy_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_rdy_q, d_rdy_d;
  logic              grant_data;

  always_comb begin
    state_d     = state_q;
    win_data_d  = win_data_q;
    is_store_d  = is_store_q;
    starve_d    = starve_q;
    wd_d        = wd_q;
    err_d       = err_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_rdy_d    = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_rdy_d     = 1'b0;
    grant_data  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          // Data wins a tie unless fetch has already been passed over STARVE_MAX times.
          grant_data  = bus.d_req && !(bus.if_req && (starve_q == STARVE_LIM));
          win_data_d  = grant_data;
          is_store_d  = grant_data && bus.d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_data && bus.d_we;
          mem_addr_d  = grant_data ? bus.d_addr : bus.if_addr;
          mem_wdata_d = grant_data ? bus.d_wdata : '0;
          if (!grant_data) begin
            starve_d = '0;
          end else if (bus.if_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.mem_valid) begin
          state_d = RESP;
          if (win_data_q) begin
            d_rdata_d = is_store_q ? '0 : bus.mem_rdata;
            d_rdy_d   = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata[31:0];
            if_rdy_d   = 1'b1;
          end
        end else if (wd_q == WD_LAST) begin
          // Hung memory: complete with zero data so the core keeps running.
          state_d = RESP;
          err_d   = 1'b1;
          if (win_data_q) begin
            d_rdata_d = '0;
            d_rdy_d   = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_rdy_d   = 1'b1;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q     <= IDLE;
      win_data_q  <= 1'b0;
      is_store_q  <= 1'b0;
      starve_q    <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_rdy_q    <= 1'b0;
      d_rdata_q   <= '0;
      d_rdy_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_data_q  <= win_data_d;
      is_store_q  <= is_store_d;
      starve_q    <= starve_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_rdy_q    <= if_rdy_d;
      d_rdata_q   <= d_rdata_d;
      d_rdy_q     <= d_rdy_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_rdy    = if_rdy_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_rdy     = d_rdy_q;
  assign bus.err       = err_q;

endmodule
